buck_step_scheduler: RTL
========================

# buck_step_scheduler

Time-step sequencer for the fixed-point buck-converter solver. Each simulated time step, it updates the switched source voltage from a PWM pattern, then strobes the solver datapath through its two half-steps: the inductor/capacitor companion-current update, then the output-voltage update. It waits on a done handshake for each half-step and reports a sample-valid pulse. It sits between host/testbench control and the solver datapath, replacing the free-running phase toggle.

## Interface
- DATA_W, 32, source/voltage word width, Q16.16 signed
- CNT_W, 10, PWM period/duty counter width (time steps)
- TIMEOUT, 64, max clock cycles to wait for a done before error
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- run_i  in  1  level; continuous stepping while high
- step_i  in  1  pulse; one time step when idle and run_i low
- period_i  in  CNT_W  PWM period in time steps (0 treated as 1)
- duty_i  in  CNT_W  on-steps per period
- vin_i  in  DATA_W  source voltage applied while switch on
- e_val_o  out  DATA_W  current source voltage to datapath
- cur_start_o  out  1  one-cycle strobe: run current update
- cur_done_i  in  1  datapath finished current update
- volt_start_o  out  1  one-cycle strobe: run voltage update
- volt_done_i  in  1  datapath finished voltage update
- sample_valid_o  out  1  one-cycle pulse: v_2 for this step valid
- step_count_o  out  32  completed time steps, wraps at 2^32
- busy_o  out  1  high in any state except IDLE
- err_o  out  1  sticky handshake-timeout flag

## Operation
- States: IDLE, SRC, CUR, VOLT, DONE.
- IDLE: if run_i, or step_i with run_i low → SRC. step_i while busy is ignored.
- SRC (1 cycle): evaluates the PWM; e_val_o = vin_i if pwm_cnt < duty_lat, else 0. Advances pwm_cnt, wrapping to 0 at period_lat−1. → CUR.
- CUR: cur_start_o high on the first cycle only. Leaves on cur_done_i sampled high in any later cycle; done in the start cycle is ignored. → VOLT.
- VOLT: same rule with volt_start_o/volt_done_i. → DONE.
- DONE (1 cycle): sample_valid_o=1, step_count_o+1. → SRC if run_i, else IDLE.
- PWM latch: period_i/duty_i latched into period_lat/duty_lat in SRC when pwm_cnt==0, so changes take effect only at a period boundary.
- PWM limits: duty_lat ≥ period_lat → always on; duty_lat=0 → always off.
- Timeout: a wait counter clears on CUR/VOLT entry. If it reaches TIMEOUT without done, err_o is set and the FSM returns to IDLE without pulsing sample_valid_o. err_o clears only on reset.
- run_i falling mid-step: the current step completes, then IDLE.
- Reset values: state IDLE, e_val_o 0, all strobes 0, step_count_o 0, pwm_cnt 0, period_lat 1, duty_lat 0, err_o 0, busy_o 0.

## Timing
- From IDLE, run_i high at edge N: SRC at N+1, cur_start_o at N+2.
- Minimum step with done one cycle after each start: 6 cycles (SRC1, CUR2, VOLT2, DONE1). Back-to-back continuous steps: 6 cycles each.
- e_val_o is registered; it changes only on exiting SRC and holds stable through CUR, VOLT and DONE.
- Start strobes and sample_valid_o are registered single-cycle pulses, never high two consecutive cycles.
- Reset asserted mid-step: all outputs reach reset values on that edge; pending dones are discarded.

## Structure
- Package buck_sim_pkg: state enum, Q16.16 typedef and FRAC_W=16, default TIMEOUT, and shared solver constants so datapath and scheduler agree on the format.
- Sub-module pwm_source_gen: pwm_cnt, period/duty latching, e_val register, and an advance input driven in SRC. The FSM, handshake, timeout and counters stay in the top.

## Test plan
- period_i=4, duty_i=2, vin_i=0x000A_0000, run_i high, done one cycle after each start → e_val_o sequence 10,10,0,0,10…; sample_valid_o every 6 cycles; step_count_o=8 after 48 cycles.
- step_i pulse with run_i low → exactly one start pair and one sample_valid_o; return to IDLE. A second step_i while busy is ignored.
- volt_done_i held low → err_o=1 at TIMEOUT cycles after volt_start_o; FSM IDLE; no sample_valid_o; step_count_o unchanged.
- duty_i changed 2→3 mid-period → old duty holds until pwm_cnt wraps; the new pattern starts on the next period. duty_i=0 → e_val_o always 0; duty_i=5 with period 4 → always vin_i.
- cur_done_i high in the same cycle as cur_start_o and then never again → no advance; timeout fires.
- rst_ni low during VOLT → next cycle all outputs at reset values; after release with run_i high, the first e_val_o equals vin_i (duty_lat reloads at pwm_cnt 0).

Source files
------------

// File: rtl/buck_sim_pkg.sv
// Shared types and constants for the fixed-point buck-converter solver.
// Scheduler and datapath import this so both agree on the Q16.16 format.
package buck_sim_pkg;

    localparam int unsigned FRAC_W          = 16;
    localparam int unsigned Q_W             = 32;
    localparam int unsigned CNT_W_DEFAULT   = 10;
    localparam int unsigned TIMEOUT_DEFAULT = 64;

    typedef logic signed [Q_W-1:0] q16_16_t;

    localparam q16_16_t Q_ONE  = 32'sh0001_0000;
    localparam q16_16_t Q_ZERO = 32'sh0000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StSrc,
        StCur,
        StVolt,
        StDone
    } state_e;

    function automatic q16_16_t int_to_q(input int v);
        return q16_16_t'(v) <<< FRAC_W;
    endfunction

endpackage

// File: rtl/pwm_source_gen.sv
// PWM source generator: period/duty latching at period boundaries and the
// registered switched-source voltage, advanced once per time step.
module pwm_source_gen
    import buck_sim_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              advance_i,
    input  logic [CNT_W-1:0]  period_i,
    input  logic [CNT_W-1:0]  duty_i,
    input  logic [DATA_W-1:0] vin_i,
    output logic [DATA_W-1:0] e_val_o
);

    logic [CNT_W-1:0]  pwm_cnt_q;
    logic [CNT_W-1:0]  period_lat_q;
    logic [CNT_W-1:0]  duty_lat_q;
    logic [DATA_W-1:0] e_val_q;
    logic [CNT_W-1:0]  period_eff;
    logic [CNT_W-1:0]  duty_eff;

    // At a period boundary the fresh inputs apply to this very step.
    always_comb begin
        period_eff = period_lat_q;
        duty_eff   = duty_lat_q;
        if (pwm_cnt_q == '0) begin
            period_eff = (period_i == '0) ? CNT_W'(1) : period_i;
            duty_eff   = duty_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pwm_cnt_q    <= '0;
            period_lat_q <= CNT_W'(1);
            duty_lat_q   <= '0;
            e_val_q      <= '0;
        end else if (advance_i) begin
            period_lat_q <= period_eff;
            duty_lat_q   <= duty_eff;
            e_val_q      <= (pwm_cnt_q < duty_eff) ? vin_i : '0;
            pwm_cnt_q    <= (pwm_cnt_q >= period_eff - CNT_W'(1)) ? '0 : pwm_cnt_q + CNT_W'(1);
        end
    end

    assign e_val_o = e_val_q;

endmodule

// File: rtl/buck_step_scheduler.sv
// Time-step sequencer: source update, then current and voltage half-steps
// with done handshakes, a timeout guard and a per-step sample-valid pulse.
module buck_step_scheduler
    import buck_sim_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic              step_i,
    input  logic [CNT_W-1:0]  period_i,
    input  logic [CNT_W-1:0]  duty_i,
    input  logic [DATA_W-1:0] vin_i,
    output logic [DATA_W-1:0] e_val_o,
    output logic              cur_start_o,
    input  logic              cur_done_i,
    output logic              volt_start_o,
    input  logic              volt_done_i,
    output logic              sample_valid_o,
    output logic [31:0]       step_count_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              cur_start_q, cur_start_d;
    logic              volt_start_q, volt_start_d;
    logic              sample_valid_q, sample_valid_d;
    logic              err_q, err_d;
    logic [31:0]       count_q, count_d;
    logic              advance;

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        cur_start_d    = 1'b0;
        volt_start_d   = 1'b0;
        sample_valid_d = 1'b0;
        err_d          = err_q;
        count_d        = count_q;
        advance        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run_i || step_i) state_d = StSrc;
            end
            StSrc: begin
                advance     = 1'b1;
                cur_start_d = 1'b1;
                wait_d      = '0;
                state_d     = StCur;
            end
            StCur: begin
                // A done coinciding with the start strobe belongs to no request.
                if (!cur_start_q && cur_done_i) begin
                    volt_start_d = 1'b1;
                    wait_d       = '0;
                    state_d      = StVolt;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StVolt: begin
                if (!volt_start_q && volt_done_i) begin
                    sample_valid_d = 1'b1;
                    count_d        = count_q + 32'd1;
                    state_d        = StDone;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StDone: begin
                state_d = run_i ? StSrc : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            wait_q         <= '0;
            cur_start_q    <= 1'b0;
            volt_start_q   <= 1'b0;
            sample_valid_q <= 1'b0;
            err_q          <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            cur_start_q    <= cur_start_d;
            volt_start_q   <= volt_start_d;
            sample_valid_q <= sample_valid_d;
            err_q          <= err_d;
            count_q        <= count_d;
        end
    end

    pwm_source_gen #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_pwm (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .advance_i (advance),
        .period_i  (period_i),
        .duty_i    (duty_i),
        .vin_i     (vin_i),
        .e_val_o   (e_val_o)
    );

    assign cur_start_o    = cur_start_q;
    assign volt_start_o   = volt_start_q;
    assign sample_valid_o = sample_valid_q;
    assign step_count_o   = count_q;
    assign busy_o         = (state_q != StIdle);
    assign err_o          = err_q;

endmodule
